mem_stage_bytelane: RTL and testbench
=====================================

Name: mem_stage_bytelane

Overview:
- Parametrised successor of the single-word MEM pipeline stage.
- Holds a synchronous on-chip data memory and supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Registers the MEM/WB pipeline boundary behind a valid/ready handshake so WB can stall the stage.
- Sits between the EX stage outputs and the WB stage.

Parameters:
- DATA_W, 32, datapath width; fixed at 32 for MIPS byte-lane logic, other values are illegal.
- DEPTH, 1024, memory depth in words; must be a power of 2.
- ADDR_W, 10, word-index width; must equal log2(DEPTH).
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX presents a valid op.
- in_ready  out  1  stage accepts the op this cycle.
- in_op  in  4  memory op: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 are treated as NONE.
- in_alu_res  in  DATA_W  effective address, or ALU result when in_op=NONE.
- in_rt_data  in  DATA_W  store data.
- in_rd  in  RD_W  destination register.
- in_w_reg_ena  in  1  register write enable.
- in_wb_sel  in  1  WB source select (1 = memory data).
- out_valid  out  1  registered op valid toward WB.
- out_ready  in  1  WB accepts the op.
- out_mem_data  out  DATA_W  extended load data.
- out_alu_res  out  DATA_W  registered in_alu_res.
- out_rd  out  RD_W  registered in_rd.
- out_w_reg_ena  out  1  registered write enable.
- out_wb_sel  out  1  registered in_wb_sel.
- out_addr_err  out  1  misaligned access flag; only driven when ADDR_EXC_EN is defined.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid, out_mem_data, out_alu_res, out_rd, out_w_reg_ena, out_wb_sel and out_addr_err all go to 0. Memory contents are not reset.
- Reset mid-operation: the held op is dropped. No store happens on any edge where rst_n=0.
- Handshake: in_ready = !out_valid || out_ready, combinational.
- Accept = in_valid && in_ready. On an accept edge:
  - the output register loads all in_* fields;
  - out_valid is set to 1.
- If out_valid=1 and out_ready=1 with no accept, out_valid clears to 0.
- While out_valid=1 and out_ready=0, every out_* signal holds stable.
- Latency: exactly 1 cycle from accept to out_valid. Throughput is 1 op per cycle when out_ready stays high.
- Word index = in_alu_res[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Memory is little-endian; byte offset b = in_alu_res[1:0].
- Stores write on the accept edge only:
  - SB writes byte lane b with rt[7:0];
  - SH writes lanes {b[1],0} and {b[1],1} with rt[15:0];
  - SW writes all four lanes.
  - Non-enabled lanes keep their contents.
- Loads read the array at the accept address and register the extended result into out_mem_data:
  - LB sign-extends byte b; LBU zero-extends byte b;
  - LH sign-extends the halfword at b[1]; LHU zero-extends it;
  - LW returns the whole word.
- Stores and NONE register out_mem_data = 0.
- Read-after-write: a store accepted at edge N followed by a load to the same word at edge N+1 returns the new data. Only one op is accepted per edge, so no same-edge conflict exists.
- No write ever occurs while the stage is stalled (accept=0).

Optional Feature:
- Macro: MEM_STAGE_ADDR_EXC_EN.
- Defined: a misaligned access sets out_addr_err=1 for that op. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. For such an op:
  - the store is suppressed;
  - out_w_reg_ena is forced to 0;
  - out_mem_data = 0.
- Not defined: out_addr_err is tied to 0. The low address bits are ignored for alignment: halfword uses b[1] only, word ignores b[1:0]. No suppression occurs.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with out_valid=1 -> all outputs are 0 immediately. After release with in_valid=0, out_valid stays 0.
- Store/load round-trip: SW 0x8899AABB @0x10, then LB @0x11 -> 0xFFFFFFAA. LBU @0x11 -> 0x000000AA. LH @0x12 -> 0xFFFF8899. LHU @0x10 -> 0x0000AABB. LW @0x10 -> 0x8899AABB.
- Byte-lane merge: SW 0 @0x20, SB 0x5A @0x23, SH 0x1234 @0x20 -> LW @0x20 returns 0x5A001234.
- Back-to-back RAW with stall: SW 0xDEADBEEF @0x40, then LW @0x40 the next cycle; hold out_ready=0 for 3 cycles -> in_ready=0 during the stall, outputs stable, and the load delivers 0xDEADBEEF once out_ready=1.
- Wrap-around with DEPTH=1024: SW 0xCAFEF00D @0x1000 -> LW @0x0 returns 0xCAFEF00D.
- Misaligned LW @0x42 with rd=8, w_reg_ena=1:
  - with MEM_STAGE_ADDR_EXC_EN: out_addr_err=1, out_w_reg_ena=0, and a misaligned SW leaves memory unchanged;
  - without the macro: the op returns the word @0x40 and out_addr_err=0.

Source files
------------

// File: rtl/mem_stage_bytelane.sv
// mem_stage_bytelane: MEM pipeline stage with byte-lane data memory and a
// registered MEM/WB boundary behind a valid/ready handshake.
// Optional build macro: MEM_STAGE_ADDR_EXC_EN enables misaligned-access
// detection (flag, store suppression, write-enable kill). Without it the
// low address bits are simply ignored for alignment and out_addr_err is 0.
module mem_stage_bytelane #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_w_reg_ena,
  input  logic              in_wb_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_w_reg_ena,
  output logic              out_wb_sel,
  output logic              out_addr_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_mem_data_q, out_mem_data_d;
  logic [DATA_W-1:0] out_alu_res_q, out_alu_res_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic              out_w_reg_ena_q, out_w_reg_ena_d;
  logic              out_wb_sel_q, out_wb_sel_d;
  logic              out_addr_err_q, out_addr_err_d;

  // Word-wide array split into byte lanes so partial stores touch only their lanes.
  logic [3:0][7:0]   mem_q [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        b_off;
  logic              misalign;
  logic [3:0]        byte_we;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign word_idx = in_alu_res[ADDR_W+1:2];
  assign b_off    = in_alu_res[1:0];

`ifdef MEM_STAGE_ADDR_EXC_EN
  // Halfword ops need bit 0 clear, word ops need both low bits clear.
  always_comb begin
    misalign = 1'b0;
    case (in_op)
      OP_LH, OP_LHU, OP_SH: misalign = b_off[0];
      OP_LW, OP_SW:         misalign = (b_off != 2'b00);
      default:              misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Store lane enables and lane-replicated write data; a misaligned store writes nothing.
  always_comb begin
    byte_we = 4'b0000;
    wr_data = in_rt_data;
    case (in_op)
      OP_SB: begin
        byte_we[b_off] = 1'b1;
        wr_data        = {4{in_rt_data[7:0]}};
      end
      OP_SH: begin
        byte_we = b_off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{in_rt_data[15:0]}};
      end
      OP_SW:   byte_we = 4'b1111;
      default: byte_we = 4'b0000;
    endcase
    if (misalign) byte_we = 4'b0000;
  end

  // Memory write on accept only. The reset branch is empty on purpose: contents
  // are never cleared, but no write may land on an edge while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (accept) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_we[l]) mem_q[word_idx][l] <= wr_data[8*l +: 8];
      end
    end
  end

  // Read the addressed word and extend the selected byte/halfword.
  always_comb begin
    rd_word   = mem_q[word_idx];
    byte_sel  = rd_word[{b_off, 3'b000} +: 8];
    half_sel  = b_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (in_op)
      OP_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      OP_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
      OP_LW:   load_data = rd_word;
      default: load_data = '0;
    endcase
    if (misalign) load_data = '0;
  end

  // Next state of the MEM/WB register: load on accept, drop valid on a drain, else hold.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_mem_data_d  = out_mem_data_q;
    out_alu_res_d   = out_alu_res_q;
    out_rd_d        = out_rd_q;
    out_w_reg_ena_d = out_w_reg_ena_q;
    out_wb_sel_d    = out_wb_sel_q;
    out_addr_err_d  = out_addr_err_q;
    if (accept) begin
      out_valid_d     = 1'b1;
      out_mem_data_d  = load_data;
      out_alu_res_d   = in_alu_res;
      out_rd_d        = in_rd;
      out_w_reg_ena_d = in_w_reg_ena && !misalign;
      out_wb_sel_d    = in_wb_sel;
      out_addr_err_d  = misalign;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // MEM/WB pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_mem_data_q  <= '0;
      out_alu_res_q   <= '0;
      out_rd_q        <= '0;
      out_w_reg_ena_q <= 1'b0;
      out_wb_sel_q    <= 1'b0;
      out_addr_err_q  <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_mem_data_q  <= out_mem_data_d;
      out_alu_res_q   <= out_alu_res_d;
      out_rd_q        <= out_rd_d;
      out_w_reg_ena_q <= out_w_reg_ena_d;
      out_wb_sel_q    <= out_wb_sel_d;
      out_addr_err_q  <= out_addr_err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_mem_data  = out_mem_data_q;
  assign out_alu_res   = out_alu_res_q;
  assign out_rd        = out_rd_q;
  assign out_w_reg_ena = out_w_reg_ena_q;
  assign out_wb_sel    = out_wb_sel_q;
  assign out_addr_err  = out_addr_err_q;

endmodule

// File: tb/tb_mem_stage_bytelane.sv
// Scoreboard bench for mem_stage_bytelane: the driver pushes the expected
// WB-side record on each accept, a monitor pops and compares on each transfer.
module tb_mem_stage_bytelane;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_alu_res;
  logic [31:0] in_rt_data;
  logic [4:0]  in_rd;
  logic        in_w_reg_ena;
  logic        in_wb_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mem_data;
  logic [31:0] out_alu_res;
  logic [4:0]  out_rd;
  logic        out_w_reg_ena;
  logic        out_wb_sel;
  logic        out_addr_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        wre;
    logic        wbsel;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  mem_stage_bytelane #(.DATA_W(32), .DEPTH(1024), .ADDR_W(10), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_alu_res(in_alu_res), .in_rt_data(in_rt_data), .in_rd(in_rd),
    .in_w_reg_ena(in_w_reg_ena), .in_wb_sel(in_wb_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_mem_data(out_mem_data),
    .out_alu_res(out_alu_res), .out_rd(out_rd), .out_w_reg_ena(out_w_reg_ena),
    .out_wb_sel(out_wb_sel), .out_addr_err(out_addr_err)
  );

  always #5 clk = ~clk;

  // Monitor: a transfer to WB happens on the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t got, e;
      got = '{mem: out_mem_data, alu: out_alu_res, rd: out_rd,
              wre: out_w_reg_ena, wbsel: out_wb_sel, err: out_addr_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got mem=%h alu=%h (no op expected)", out_mem_data, out_alu_res);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard got mem=%h alu=%h rd=%0d wre=%b wbsel=%b err=%b exp mem=%h alu=%h rd=%0d wre=%b wbsel=%b err=%b",
                   got.mem, got.alu, got.rd, got.wre, got.wbsel, got.err,
                   e.mem, e.alu, e.rd, e.wre, e.wbsel, e.err);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [4:0] rd, input logic wre, input logic wbsel,
                      input logic [31:0] exp_mem, input logic exp_wre, input logic exp_err);
    bit got = 0;
    int n = 0;
    in_op = op; in_alu_res = addr; in_rt_data = data; in_rd = rd;
    in_w_reg_ena = wre; in_wb_sel = wbsel; in_valid = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{mem: exp_mem, alu: addr, rd: rd, wre: exp_wre, wbsel: wbsel, err: exp_err});
        got = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout op=%0d addr=%h got in_ready=%b required 1", op, addr, in_ready);
    end
  endtask

  task automatic ld(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] exp_mem);
    send(op, addr, 32'h0, rd, 1'b1, 1'b1, exp_mem, 1'b1, 1'b0);
  endtask

  task automatic st(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    send(op, addr, data, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({out_valid, out_mem_data, out_alu_res, out_rd, out_w_reg_ena, out_wb_sel, out_addr_err} !== '0) begin
      errors++;
      $display("FAIL %s got valid=%b mem=%h alu=%h rd=%0d wre=%b wbsel=%b err=%b required all 0",
               name, out_valid, out_mem_data, out_alu_res, out_rd, out_w_reg_ena, out_wb_sel, out_addr_err);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_alu_res = '0; in_rt_data = '0;
    in_rd = '0; in_w_reg_ena = 1'b0; in_wb_sel = 1'b0; out_ready = 1'b1;
    #1;
    check_all_zero("reset_initial");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // NONE passthrough (including an unused opcode)
    send(4'd0,  32'h12345678, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    send(4'd12, 32'h0000ABCD, 32'h11111111, 5'd4, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Store/load round-trip
    st(4'd8, 32'h10, 32'h8899AABB);
    ld(4'd1, 32'h11, 5'd1, 32'hFFFFFFAA);
    ld(4'd2, 32'h11, 5'd2, 32'h000000AA);
    ld(4'd3, 32'h12, 5'd3, 32'hFFFF8899);
    ld(4'd4, 32'h10, 5'd4, 32'h0000AABB);
    ld(4'd5, 32'h10, 5'd5, 32'h8899AABB);
    ld(4'd1, 32'h10, 5'd6, 32'hFFFFFFBB);

    // Byte-lane merge
    st(4'd8, 32'h20, 32'h00000000);
    st(4'd6, 32'h23, 32'h0000005A);
    st(4'd7, 32'h20, 32'h00001234);
    ld(4'd5, 32'h20, 5'd7, 32'h5A001234);
    ld(4'd1, 32'h20, 5'd8, 32'h00000034);
    ld(4'd3, 32'h22, 5'd9, 32'h00005A00);
    drain();

    // Back-to-back RAW then a 3-cycle WB stall holding the load
    st(4'd8, 32'h40, 32'hDEADBEEF);
    ld(4'd5, 32'h40, 5'd10, 32'hDEADBEEF);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_mem_data !== 32'hDEADBEEF ||
          out_alu_res !== 32'h40 || out_rd !== 5'd10) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got in_ready=%b valid=%b mem=%h alu=%h rd=%0d required 0 1 deadbeef 00000040 10",
                 i, in_ready, out_valid, out_mem_data, out_alu_res, out_rd);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Address wrap modulo DEPTH words
    st(4'd8, 32'h1000, 32'hCAFEF00D);
    ld(4'd5, 32'h0, 5'd11, 32'hCAFEF00D);

    // Misaligned accesses
`ifdef MEM_STAGE_ADDR_EXC_EN
    send(4'd5, 32'h42, 32'h0, 5'd8, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    send(4'd8, 32'h41, 32'h11111111, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    ld(4'd5, 32'h40, 5'd12, 32'hDEADBEEF);
    send(4'd3, 32'h11, 32'h0, 5'd13, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
`else
    ld(4'd5, 32'h42, 5'd8, 32'hDEADBEEF);
    st(4'd8, 32'h41, 32'h11111111);
    ld(4'd5, 32'h40, 5'd12, 32'h11111111);
    ld(4'd3, 32'h11, 5'd13, 32'hFFFFAABB);
`endif
    drain();

    // Asynchronous reset while an op is held
    out_ready = 1'b0;
    ld(4'd5, 32'h10, 5'd14, 32'h8899AABB);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_midstream");
    exp_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle got out_valid=%b required 0", out_valid);
      end
    end
    @(posedge clk); #1;

    // Memory survives reset
    ld(4'd5, 32'h10, 5'd15, 32'h8899AABB);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
